// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues one instruction-memory read per instruction, holds it until commit.
// Optional build macro MISALIGN_TRAP_EN: a misaligned redirect traps (sticky misalign, fetch halts).
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   S_FETCH | request pc from memory, held until the memory accepts it
//   S_WAIT  | request accepted, waiting for the response pulse
//   S_ISSUE | instruction presented to the decoder, waiting for commit
//   S_HALT  | fetch stopped by ecall (or a misalign trap), left only via reset
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] pc,
  input  logic        commit,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  input  logic        halt_req,
  output logic        halted,
  output logic        misalign
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_ISSUE = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic        inst_valid_q, inst_valid_d;
`ifdef MISALIGN_TRAP_EN
  logic        misalign_q, misalign_d;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_FETCH;
      pc_q         <= RESET_PC;
      inst_q       <= NOP;
      inst_valid_q <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      misalign_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      inst_valid_q <= inst_valid_d;
`ifdef MISALIGN_TRAP_EN
      misalign_q   <= misalign_d;
`endif
    end
  end

  always_comb begin
    logic trap;
    state_d      = state_q;
    pc_d         = pc_q;
    inst_d       = inst_q;
    inst_valid_d = inst_valid_q;
    trap         = 1'b0;
`ifdef MISALIGN_TRAP_EN
    misalign_d   = misalign_q;
`endif

    unique case (state_q)
      S_FETCH: begin
        if (imem_req_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (imem_resp_valid) begin
          inst_d       = imem_resp_data;
          inst_valid_d = 1'b1;
          state_d      = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (commit) begin
          inst_valid_d = 1'b0;
          if (redirect_en) begin
`ifdef MISALIGN_TRAP_EN
            pc_d = redirect_pc;
            if (redirect_pc[1:0] != 2'b00) begin
              trap       = 1'b1;
              misalign_d = 1'b1;
            end
`else
            // Low bits are dropped so fetch always stays word aligned.
            pc_d = redirect_pc & 32'hFFFF_FFFC;
`endif
          end else begin
            pc_d = pc_q + 32'd4;
          end
          state_d = (halt_req || trap) ? S_HALT : S_FETCH;
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // Gated with reset_n so no request escapes while reset is held.
  assign imem_req_valid = (state_q == S_FETCH) && reset_n;
  assign imem_req_addr  = pc_q;
  assign inst_valid     = inst_valid_q;
  assign inst           = inst_q;
  assign pc             = pc_q;
  assign halted         = (state_q == S_HALT);
`ifdef MISALIGN_TRAP_EN
  assign misalign       = misalign_q;
`else
  assign misalign       = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: transaction-level model checked every cycle plus directed literal checks.
module tb_instr_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk;
  logic        reset_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        commit;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic        halt_req;
  logic        halted;
  logic        misalign;

  int errors = 0;
  int checks = 0;

  instr_fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .inst_valid      (inst_valid),
    .inst            (inst),
    .pc              (pc),
    .commit          (commit),
    .redirect_en     (redirect_en),
    .redirect_pc     (redirect_pc),
    .halt_req        (halt_req),
    .halted          (halted),
    .misalign        (misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h0050_0093;
  endfunction

  // Memory: answers each accepted request one cycle later; spur injects a stray response.
  logic        hs_pend;
  logic [31:0] hs_addr;
  logic        spur;
  int          hs_count = 0;

  initial begin
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'h0;
    hs_pend         = 1'b0;
    hs_addr         = 32'h0;
    forever begin
      @(negedge clk);
      hs_pend = reset_n && imem_req_valid && imem_req_ready;
      hs_addr = imem_req_addr;
      if (hs_pend) hs_count++;
      @(posedge clk);
      #1;
      imem_resp_valid = hs_pend || spur;
      imem_resp_data  = spur ? 32'hDEAD_BEEF : mem_word(hs_addr);
    end
  end

  // Transaction model: either requesting, waiting on memory, holding an instruction, or halted.
  logic        m_out, m_have, m_halt, m_mis;
  logic [31:0] m_pc, m_inst;
  wire         m_fetching = !m_halt && !m_have && !m_out;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_out  <= 1'b0;
      m_have <= 1'b0;
      m_halt <= 1'b0;
      m_mis  <= 1'b0;
      m_pc   <= RESET_PC;
      m_inst <= NOP;
    end else if (m_fetching) begin
      if (imem_req_ready) m_out <= 1'b1;
    end else if (m_out) begin
      if (imem_resp_valid) begin
        m_out  <= 1'b0;
        m_have <= 1'b1;
        m_inst <= imem_resp_data;
      end
    end else if (m_have && commit) begin
      m_have <= 1'b0;
      if (halt_req) m_halt <= 1'b1;
      if (redirect_en) begin
`ifdef MISALIGN_TRAP_EN
        m_pc <= redirect_pc;
        if (redirect_pc[1:0] != 2'b00) begin
          m_mis  <= 1'b1;
          m_halt <= 1'b1;
        end
`else
        m_pc <= {redirect_pc[31:2], 2'b00};
`endif
      end else begin
        m_pc <= m_pc + 32'd4;
      end
    end
  end

  always @(negedge clk) begin
    if (!reset_n) begin
      check("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
      check("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
      check("rst_pc", pc, RESET_PC);
      check("rst_inst", inst, NOP);
      check("rst_halted", {31'b0, halted}, 32'd0);
      check("rst_misalign", {31'b0, misalign}, 32'd0);
    end else begin
      check("m_req_valid", {31'b0, imem_req_valid}, {31'b0, m_fetching});
      if (m_fetching) check("m_req_addr", imem_req_addr, m_pc);
      check("m_inst_valid", {31'b0, inst_valid}, {31'b0, m_have});
      if (m_have) check("m_inst", inst, m_inst);
      check("m_pc", pc, m_pc);
      check("m_halted", {31'b0, halted}, {31'b0, m_halt});
      check("m_misalign", {31'b0, misalign}, {31'b0, m_mis});
    end
  end

  task automatic wait_req(input string name);
    int n = 0;
    @(negedge clk);
    while (!imem_req_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!imem_req_valid) begin
      checks++;
      errors++;
      $display("FAIL %s: req_valid timeout got 0 expected 1", name);
    end
  endtask

  task automatic wait_inst(input string name);
    int n = 0;
    @(negedge clk);
    while (!inst_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!inst_valid) begin
      checks++;
      errors++;
      $display("FAIL %s: inst_valid timeout got 0 expected 1", name);
    end
  endtask

  // Called at a negedge with inst_valid high; commit lasts one cycle.
  task automatic do_commit(input logic red, input logic [31:0] rpc, input logic hlt);
    commit      = 1'b1;
    redirect_en = red;
    redirect_pc = rpc;
    halt_req    = hlt;
    @(posedge clk);
    #1;
    commit      = 1'b0;
    redirect_en = 1'b0;
    redirect_pc = 32'h0;
    halt_req    = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int hs0;
    reset_n        = 1'b0;
    imem_req_ready = 1'b1;
    commit         = 1'b0;
    redirect_en    = 1'b0;
    redirect_pc    = 32'h0;
    halt_req       = 1'b0;
    spur           = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    // 1: first fetch and latency
    @(negedge clk);
    check("t1_req_valid", {31'b0, imem_req_valid}, 32'd1);
    check("t1_req_addr", imem_req_addr, 32'h0);
    n = 0;
    while (!inst_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("t1_latency", 32'(n), 32'd2);
    check("t1_inst", inst, 32'h0050_0093);
    check("t1_pc", pc, 32'h0);
    imem_req_ready = 1'b0;
    do_commit(1'b0, 32'h0, 1'b0);
    wait_req("t1_next");
    check("t1_next_addr", imem_req_addr, 32'h4);

    // 2: request held while memory stalls
    hs0 = hs_count;
    for (int i = 0; i < 5; i++) begin
      check("t2_hold_valid", {31'b0, imem_req_valid}, 32'd1);
      check("t2_hold_addr", imem_req_addr, 32'h4);
      @(negedge clk);
    end
    check("t2_no_handshake", 32'(hs_count), 32'(hs0));
    @(posedge clk);
    #1 imem_req_ready = 1'b1;
    wait_inst("t2_inst");
    check("t2_one_request", 32'(hs_count), 32'(hs0 + 1));
    check("t2_inst", inst, 32'h0050_0097);

    // 3: stray response in ISSUE, then redirect
    spur = 1'b1;
    @(posedge clk);
    #2 spur = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("t3_spur_inst", inst, 32'h0050_0097);
    check("t3_spur_valid", {31'b0, inst_valid}, 32'd1);
    do_commit(1'b1, 32'h0000_0100, 1'b0);
    wait_req("t3_redirect");
    check("t3_redirect_addr", imem_req_addr, 32'h100);

    // 4: halt, then reset recovery
    wait_inst("t4_inst");
    check("t4_inst", inst, 32'h0050_0193);
    hs0 = hs_count;
    do_commit(1'b0, 32'h0, 1'b1);
    @(negedge clk);
    check("t4_halted", {31'b0, halted}, 32'd1);
    check("t4_pc", pc, 32'h104);
    for (int i = 0; i < 22; i++) begin
      check("t4_no_req", {31'b0, imem_req_valid}, 32'd0);
      @(negedge clk);
    end
    check("t4_no_handshake", 32'(hs_count), 32'(hs0));
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("t4_rst_pc", pc, RESET_PC);
    check("t4_rst_halted", {31'b0, halted}, 32'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    check("t4_restart_valid", {31'b0, imem_req_valid}, 32'd1);
    check("t4_restart_addr", imem_req_addr, RESET_PC);

    // 5: PC wrap, then reset while waiting on memory
    wait_inst("t5_inst0");
    do_commit(1'b1, 32'hFFFF_FFFC, 1'b0);
    wait_inst("t5_inst_top");
    check("t5_top_pc", pc, 32'hFFFF_FFFC);
    check("t5_top_inst", inst, 32'hFFAF_FF6F);
    do_commit(1'b0, 32'h0, 1'b0);
    wait_req("t5_wrap");
    check("t5_wrap_addr", imem_req_addr, 32'h0);
    wait_inst("t5_inst1");
    do_commit(1'b1, 32'h0000_0200, 1'b0);
    wait_req("t5_req200");
    check("t5_req200_addr", imem_req_addr, 32'h200);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("t5_rst_inst_valid", {31'b0, inst_valid}, 32'd0);
    check("t5_rst_pc", pc, RESET_PC);
    check("t5_rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 reset_n = 1'b1;
    wait_inst("t5_after_rst");
    check("t5_after_rst_inst", inst, 32'h0050_0093);
    check("t5_after_rst_pc", pc, 32'h0);

    // 6: misaligned redirect
    do_commit(1'b1, 32'h0000_0102, 1'b0);
`ifdef MISALIGN_TRAP_EN
    @(negedge clk);
    check("t6_misalign", {31'b0, misalign}, 32'd1);
    check("t6_halted", {31'b0, halted}, 32'd1);
    check("t6_pc", pc, 32'h102);
    repeat (4) @(negedge clk);
    check("t6_misalign_sticky", {31'b0, misalign}, 32'd1);
`else
    wait_req("t6_aligned");
    check("t6_addr", imem_req_addr, 32'h100);
    check("t6_misalign", {31'b0, misalign}, 32'd0);
    wait_inst("t6_inst");
    check("t6_inst", inst, 32'h0050_0193);
`endif

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
